// File: rtl/gemm_tile_sequencer.sv
// Address and tag sequencer for the tiled GEMM array. Walks M x K x N in tiles (mt outer, nt middle, kt inner),
// tags operand beats aligned to the SRAM read latency, and issues the C write once a tile's accumulation completes.
module gemm_tile_sequencer #(
    parameter int TileM         = 4,
    parameter int TileN         = 4,
    parameter int TileK         = 4,
    parameter int SizeAddrWidth = 8,
    parameter int AddrWidth     = 6,
    parameter int SramLatency   = 1,
    parameter int AccLatency    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     op_valid_o,
    output logic                     op_first_o,
    output logic                     op_last_o,
    output logic [TileM-1:0]         row_mask_o,
    output logic [TileN-1:0]         col_mask_o,
    output logic [TileK-1:0]         k_mask_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int SW    = SizeAddrWidth;
    localparam int PW    = 2 * SizeAddrWidth + 1;
    localparam int LogTm = $clog2(TileM);
    localparam int LogTn = $clog2(TileN);
    localparam int LogTk = $clog2(TileK);
    localparam logic [SW-1:0] TmLow     = SW'(TileM - 1);
    localparam logic [SW-1:0] TnLow     = SW'(TileN - 1);
    localparam logic [SW-1:0] TkLow     = SW'(TileK - 1);
    localparam logic [PW-1:0] AddrSpace = PW'(2 ** AddrWidth);
    localparam logic [3:0]    DrainInit = 4'(SramLatency + AccLatency - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [AddrWidth-1:0] c_addr;
        logic [TileM-1:0]     row_mask;
        logic [TileN-1:0]     col_mask;
        logic [TileK-1:0]     k_mask;
    } beat_t;

    state_t               state_r;
    logic [SW-1:0]        k_size_r, n_size_r;
    logic [SW-1:0]        mt_cnt_r, kt_cnt_r, nt_cnt_r;
    logic [SW-1:0]        mt_r, kt_r, nt_r;
    logic [SW-1:0]        row_rem_r, col_rem_r, k_rem_r;
    logic [AddrWidth-1:0] a_addr_r, b_addr_r, c_iss_r;
    logic                 iss_valid_r, busy_r, done_r, err_r;
    logic [3:0]           drain_r;

    logic [SW-1:0]        mt_in_s, kt_in_s, nt_in_s;
    logic [PW-1:0]        ak_s, kn_s, mn_s;
    logic                 bad_s, kt_wrap_s, nt_wrap_s, mt_wrap_s;
    beat_t                iss_s;

    // Tile counts by shift plus remainder OR-reduce, and the legality check for a new request
    always_comb begin
        mt_in_s = (M_size_i >> LogTm) + SW'(|(M_size_i & TmLow));
        kt_in_s = (K_size_i >> LogTk) + SW'(|(K_size_i & TkLow));
        nt_in_s = (N_size_i >> LogTn) + SW'(|(N_size_i & TnLow));
        ak_s    = PW'(mt_in_s) * PW'(kt_in_s);
        kn_s    = PW'(kt_in_s) * PW'(nt_in_s);
        mn_s    = PW'(mt_in_s) * PW'(nt_in_s);
        bad_s   = (M_size_i == SW'(0)) || (K_size_i == SW'(0)) || (N_size_i == SW'(0)) ||
                  (ak_s > AddrSpace) || (kn_s > AddrSpace) || (mn_s > AddrSpace);
        kt_wrap_s = (kt_r == kt_cnt_r - SW'(1));
        nt_wrap_s = (nt_r == nt_cnt_r - SW'(1));
        mt_wrap_s = (mt_r == mt_cnt_r - SW'(1));
    end

    // Tag of the beat whose addresses are on the SRAM ports this cycle
    always_comb begin
        iss_s        = beat_t'(0);
        iss_s.valid  = iss_valid_r;
        iss_s.c_addr = c_iss_r;
        if (iss_valid_r) begin
            iss_s.first = (kt_r == SW'(0));
            iss_s.last  = kt_wrap_s;
            for (int i = 0; i < TileM; i++) iss_s.row_mask[i] = (32'(row_rem_r) > 32'(i));
            for (int i = 0; i < TileN; i++) iss_s.col_mask[i] = (32'(col_rem_r) > 32'(i));
            for (int i = 0; i < TileK; i++) iss_s.k_mask[i]   = (32'(k_rem_r) > 32'(i));
        end else begin
            iss_s.first    = 1'b0;
            iss_s.last     = 1'b0;
            iss_s.row_mask = TileM'(0);
            iss_s.col_mask = TileN'(0);
            iss_s.k_mask   = TileK'(0);
        end
    end

    // Control FSM: acceptance, incremental tile walk, drain and completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            k_size_r    <= SW'(0);
            n_size_r    <= SW'(0);
            mt_cnt_r    <= SW'(0);
            kt_cnt_r    <= SW'(0);
            nt_cnt_r    <= SW'(0);
            mt_r        <= SW'(0);
            kt_r        <= SW'(0);
            nt_r        <= SW'(0);
            row_rem_r   <= SW'(0);
            col_rem_r   <= SW'(0);
            k_rem_r     <= SW'(0);
            a_addr_r    <= AddrWidth'(0);
            b_addr_r    <= AddrWidth'(0);
            c_iss_r     <= AddrWidth'(0);
            iss_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            drain_r     <= 4'd0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        k_size_r  <= K_size_i;
                        n_size_r  <= N_size_i;
                        mt_cnt_r  <= mt_in_s;
                        kt_cnt_r  <= kt_in_s;
                        nt_cnt_r  <= nt_in_s;
                        mt_r      <= SW'(0);
                        kt_r      <= SW'(0);
                        nt_r      <= SW'(0);
                        row_rem_r <= M_size_i;
                        col_rem_r <= N_size_i;
                        k_rem_r   <= K_size_i;
                        if (bad_s) begin
                            state_r <= S_ERR;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state_r     <= S_RUN;
                            busy_r      <= 1'b1;
                            iss_valid_r <= 1'b1;
                            a_addr_r    <= AddrWidth'(0);
                            b_addr_r    <= AddrWidth'(0);
                            c_iss_r     <= AddrWidth'(0);
                        end
                    end
                end
                S_RUN: begin
                    if (kt_wrap_s && nt_wrap_s && mt_wrap_s) begin
                        state_r     <= S_DRAIN;
                        iss_valid_r <= 1'b0;
                        drain_r     <= DrainInit;
                    end else if (!kt_wrap_s) begin
                        kt_r     <= kt_r + SW'(1);
                        k_rem_r  <= k_rem_r - SW'(TileK);
                        a_addr_r <= a_addr_r + AddrWidth'(1);
                        b_addr_r <= b_addr_r + AddrWidth'(nt_cnt_r);
                    end else if (!nt_wrap_s) begin
                        // next column tile: A rewinds to this row's first k tile
                        kt_r      <= SW'(0);
                        nt_r      <= nt_r + SW'(1);
                        k_rem_r   <= k_size_r;
                        col_rem_r <= col_rem_r - SW'(TileN);
                        a_addr_r  <= a_addr_r - AddrWidth'(kt_cnt_r - SW'(1));
                        b_addr_r  <= AddrWidth'(nt_r + SW'(1));
                        c_iss_r   <= c_iss_r + AddrWidth'(1);
                    end else begin
                        kt_r      <= SW'(0);
                        nt_r      <= SW'(0);
                        mt_r      <= mt_r + SW'(1);
                        k_rem_r   <= k_size_r;
                        col_rem_r <= n_size_r;
                        row_rem_r <= row_rem_r - SW'(TileM);
                        a_addr_r  <= a_addr_r + AddrWidth'(1);
                        b_addr_r  <= AddrWidth'(0);
                        c_iss_r   <= c_iss_r + AddrWidth'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_r == 4'd0) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        drain_r <= drain_r - 4'd1;
                    end
                end
                S_DONE:  state_r <= S_IDLE;
                S_ERR:   state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    beat_t pipe_r [SramLatency];

    // Operand tag delay line matching the SRAM read latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < SramLatency; j++) pipe_r[j] <= beat_t'(0);
        end else begin
            pipe_r[0] <= iss_s;
            for (int j = 1; j < SramLatency; j++) pipe_r[j] <= pipe_r[j-1];
        end
    end

    logic                 tail_we_s;
    logic [AccLatency-1:0] acc_we_r;
    logic [AddrWidth-1:0] acc_addr_r [AccLatency];

    assign tail_we_s = pipe_r[SramLatency-1].valid & pipe_r[SramLatency-1].last;

    // C write delay line; the address stages only load on a write so the output holds the last one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_we_r <= AccLatency'(0);
            for (int j = 0; j < AccLatency; j++) acc_addr_r[j] <= AddrWidth'(0);
        end else begin
            acc_we_r[0] <= tail_we_s;
            if (tail_we_s) acc_addr_r[0] <= pipe_r[SramLatency-1].c_addr;
            for (int j = 1; j < AccLatency; j++) begin
                acc_we_r[j] <= acc_we_r[j-1];
                if (acc_we_r[j-1]) acc_addr_r[j] <= acc_addr_r[j-1];
            end
        end
    end

    assign sram_a_addr_o = a_addr_r;
    assign sram_b_addr_o = b_addr_r;
    assign sram_c_addr_o = acc_addr_r[AccLatency-1];
    assign sram_c_we_o   = acc_we_r[AccLatency-1];
    assign op_valid_o    = pipe_r[SramLatency-1].valid;
    assign op_first_o    = pipe_r[SramLatency-1].first;
    assign op_last_o     = pipe_r[SramLatency-1].last;
    assign row_mask_o    = pipe_r[SramLatency-1].row_mask;
    assign col_mask_o    = pipe_r[SramLatency-1].col_mask;
    assign k_mask_o      = pipe_r[SramLatency-1].k_mask;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign err_o         = err_r;
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench: two sequencer instances (latencies 1/1 and 3/2) compared cycle by cycle
// against a trace built from nested tile loops.
module tb_gemm_tile_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] m_size = 8'd0, k_size = 8'd0, n_size = 8'd0;

    logic [5:0] a0, b0, c0, a1, b1, c1;
    logic       we0, v0, f0, l0, busy0, done0, err0;
    logic       we1, v1, f1, l1, busy1, done1, err1;
    logic [3:0] rm0, cm0, km0, rm1, cm1, km1;

    always #5 clk = ~clk;

    gemm_tile_sequencer #(.SramLatency(1), .AccLatency(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a0), .sram_b_addr_o(b0), .sram_c_addr_o(c0), .sram_c_we_o(we0),
        .op_valid_o(v0), .op_first_o(f0), .op_last_o(l0),
        .row_mask_o(rm0), .col_mask_o(cm0), .k_mask_o(km0),
        .busy_o(busy0), .done_o(done0), .err_o(err0));

    gemm_tile_sequencer #(.SramLatency(3), .AccLatency(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a1), .sram_b_addr_o(b1), .sram_c_addr_o(c1), .sram_c_we_o(we1),
        .op_valid_o(v1), .op_first_o(f1), .op_last_o(l1),
        .row_mask_o(rm1), .col_mask_o(cm1), .k_mask_o(km1),
        .busy_o(busy1), .done_o(done1), .err_o(err1));

    typedef struct packed {
        logic       valid, first, last;
        logic [3:0] rm, cm, km;
        logic       we;
        logic [5:0] caddr, a, b;
        logic       busy, done, err;
    } vec_t;

    vec_t       exp_q [0:511];
    int         checks = 0;
    int         failures = 0;
    logic [5:0] last_a [2];
    logic [5:0] last_b [2];
    logic [5:0] last_c [2];

    function automatic vec_t obs(input int sel);
        vec_t o;
        if (sel == 0) o = '{v0, f0, l0, rm0, cm0, km0, we0, c0, a0, b0, busy0, done0, err0};
        else          o = '{v1, f1, l1, rm1, cm1, km1, we1, c1, a1, b1, busy1, done1, err1};
        return o;
    endfunction

    function automatic logic [3:0] lanes(input int r);
        int c;
        c = (r > 4) ? 4 : r;
        return 4'((1 << c) - 1);
    endfunction

    // Expected trace indexed by cycle offset from the start cycle; len is the done cycle
    task automatic gen(input int m, input int k, input int n, input int sel, output int len);
        int sl, al, mtn, ktn, ntn, nb, idx, kk;
        logic [5:0] aa, bb, ca;
        sl  = (sel == 0) ? 1 : 3;
        al  = (sel == 0) ? 1 : 2;
        mtn = (m + 3) / 4;
        ktn = (k + 3) / 4;
        ntn = (n + 3) / 4;
        for (int i = 0; i < 512; i++) exp_q[i] = '0;
        if (m == 0 || k == 0 || n == 0 || mtn * ktn > 64 || ktn * ntn > 64 || mtn * ntn > 64) begin
            len = 1;
            for (int i = 1; i <= 2; i++) begin
                exp_q[i].a = last_a[sel];
                exp_q[i].b = last_b[sel];
                exp_q[i].caddr = last_c[sel];
            end
            exp_q[1].done = 1'b1;
            exp_q[1].err  = 1'b1;
            return;
        end
        nb  = mtn * ntn * ktn;
        len = nb + sl + al + 1;
        idx = 0;
        for (int mt = 0; mt < mtn; mt++)
            for (int nt = 0; nt < ntn; nt++)
                for (int kt = 0; kt < ktn; kt++) begin
                    exp_q[1 + idx].a = 6'(mt * ktn + kt);
                    exp_q[1 + idx].b = 6'(kt * ntn + nt);
                    kk = 1 + idx + sl;
                    exp_q[kk].valid = 1'b1;
                    exp_q[kk].first = (kt == 0);
                    exp_q[kk].last  = (kt == ktn - 1);
                    exp_q[kk].rm    = lanes(m - mt * 4);
                    exp_q[kk].cm    = lanes(n - nt * 4);
                    exp_q[kk].km    = lanes(k - kt * 4);
                    if (kt == ktn - 1) begin
                        exp_q[kk + al].we    = 1'b1;
                        exp_q[kk + al].caddr = 6'(mt * ntn + nt);
                    end
                    idx++;
                end
        aa = last_a[sel];
        bb = last_b[sel];
        ca = last_c[sel];
        for (int i = 1; i <= len + 1; i++) begin
            if (i <= nb) begin
                aa = exp_q[i].a;
                bb = exp_q[i].b;
            end else begin
                exp_q[i].a = aa;
                exp_q[i].b = bb;
            end
            if (exp_q[i].we) ca = exp_q[i].caddr;
            else exp_q[i].caddr = ca;
            exp_q[i].busy = (i < len);
        end
        exp_q[len].done = 1'b1;
        last_a[sel] = aa;
        last_b[sel] = bb;
        last_c[sel] = ca;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    // mode 0: single pulse, 1: extra pulse at offset 4, 2: start held through the cycle after done
    task automatic run_case(input string tag, input int m, input int k, input int n,
                            input int sel, input int mode, input bit pre_started);
        int   len;
        vec_t o;
        gen(m, k, n, sel, len);
        if (!pre_started) begin
            @(negedge clk);
            m_size = 8'(m);
            k_size = 8'(k);
            n_size = 8'(n);
            set_start(sel, 1'b1);
        end
        for (int kk = 1; kk <= len + 1; kk++) begin
            @(negedge clk);
            o = obs(sel);
            checks++;
            assert (o === exp_q[kk]) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, kk, o, exp_q[kk]);
            end
            if (mode == 2) begin
                set_start(sel, 1'b1);
            end else begin
                set_start(sel, (mode == 1) && (kk == 4));
                m_size = 8'($urandom);
                k_size = 8'($urandom);
                n_size = 8'($urandom);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            last_a[s] = 6'd0;
            last_b[s] = 6'd0;
            last_c[s] = 6'd0;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        assert (obs(0) === vec_t'(0)) else begin
            failures++;
            $error("FAIL reset0 observed=%h expected=0", obs(0));
        end
        checks++;
        assert (obs(1) === vec_t'(0)) else begin
            failures++;
            $error("FAIL reset1 observed=%h expected=0", obs(1));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_case("cube8", 8, 8, 8, 0, 0, 1'b0);
        run_case("ragged", 5, 4, 6, 0, 0, 1'b0);
        run_case("err_m0", 0, 8, 8, 0, 0, 1'b0);
        run_case("err_65", 20, 52, 4, 0, 0, 1'b0);
        run_case("max64", 32, 32, 4, 0, 0, 1'b0);
        run_case("ign_start", 8, 8, 8, 0, 1, 1'b0);
        run_case("hold", 4, 8, 4, 0, 2, 1'b0);
        run_case("hold_next", 4, 8, 4, 0, 0, 1'b1);
        run_case("lat32", 8, 8, 8, 1, 0, 1'b0);
        run_case("lat32_rag", 7, 9, 3, 1, 0, 1'b0);
        run_case("err_kt", 4, 0, 4, 1, 0, 1'b0);

        // abort a run mid-way with an asynchronous reset
        @(negedge clk);
        m_size = 8'd8;
        k_size = 8'd8;
        n_size = 8'd8;
        start0 = 1'b1;
        for (int kk = 1; kk <= 5; kk++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        assert (obs(0) === vec_t'(0)) else begin
            failures++;
            $error("FAIL midrst observed=%h expected=0", obs(0));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_a[s] = 6'd0;
            last_b[s] = 6'd0;
            last_c[s] = 6'd0;
        end
        for (int kk = 0; kk < 16; kk++) begin
            @(negedge clk);
            checks++;
            assert (obs(0) === vec_t'(0)) else begin
                failures++;
                $error("FAIL post_abort cyc=%0d observed=%h expected=0", kk, obs(0));
            end
        end
        run_case("after_rst", 4, 4, 4, 0, 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_case("rand", int'($urandom_range(0, 24)), int'($urandom_range(1, 24)),
                     int'($urandom_range(1, 24)), r % 2, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
